// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Groups the requester handshakes, the RAM port and the user IO ports of the
// memory port arbiter into a single bundle.
//   if_*  : instruction fetch request/ack with read data
//   dm_*  : load/store request/ack with write and read data
//   ram_* : single-port synchronous RAM address/data/strobes
//   io_*  : memory-mapped user input ports and registered output port
// The arbiter connects through the slave modport; the environment (requesters,
// RAM and IO) uses the master modport.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] io_in0;
    logic [31:0] io_in1;
    logic [31:0] io_out;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack,
        output ram_addr, ram_wdata, ram_re, ram_we,
        input  ram_rdata,
        input  io_in0, io_in1,
        output io_out
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack,
        input  ram_addr, ram_wdata, ram_re, ram_we,
        output ram_rdata,
        output io_in0, io_in1,
        input  io_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// the load/store unit (DM). Each access runs IDLE -> ISSUE -> WAIT -> DONE
// (reads), IDLE -> ISSUE -> DONE (writes) or IDLE -> DONE (DM accesses to the
// memory-mapped user ports), and completes with a one-cycle ack pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of mem_port_arbiter_if (requesters, RAM port, user IO)
// Parameters:
//   RD_LAT      : RAM read latency in cycles from the ram_re cycle (1..7)
//   IO_IN0_ADDR : DM read address of user port 0
//   IO_IN1_ADDR : DM read address of user port 1
//   IO_OUT_ADDR : DM write address of the output port
module mem_port_arbiter #(
    parameter int          RD_LAT      = 1,
    parameter logic [31:0] IO_IN0_ADDR = 32'h0000FFF8,
    parameter logic [31:0] IO_IN1_ADDR = 32'h0000FFFC,
    parameter logic [31:0] IO_OUT_ADDR = 32'h0000FFFC
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_DM   = 1'b1;
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic [2:0]  lat_cnt;

    logic        grant_dm;
    logic        any_req;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        dm_io_rd;
    logic        dm_io_wr;
    logic        io_hit;

    // On a tie the requester that did not win last time is granted.
    assign any_req   = bus.if_req | bus.dm_req;
    assign grant_dm  = bus.dm_req & (~bus.if_req | (last_grant == OWN_IF));
    assign sel_addr  = grant_dm ? bus.dm_addr : bus.if_addr;
    assign sel_wdata = grant_dm ? bus.dm_wdata : 32'h0;
    assign sel_we    = grant_dm & bus.dm_we;

    // Only DM accesses are IO-decoded. Writes to the input port addresses are
    // swallowed (acked without effect) rather than reaching RAM.
    assign dm_io_rd  = (bus.dm_addr == IO_IN0_ADDR) || (bus.dm_addr == IO_IN1_ADDR);
    assign dm_io_wr  = dm_io_rd || (bus.dm_addr == IO_OUT_ADDR);
    assign io_hit    = grant_dm && (bus.dm_we ? dm_io_wr : dm_io_rd);

    // The ram_addr/ram_wdata/ram_we registers double as the latched request:
    // loaded on grant, driven during ISSUE, cleared on leaving ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            last_grant    <= OWN_DM;
            lat_cnt       <= 3'd0;
            bus.if_rdata  <= 32'h0;
            bus.if_ack    <= 1'b0;
            bus.dm_rdata  <= 32'h0;
            bus.dm_ack    <= 1'b0;
            bus.ram_addr  <= 32'h0;
            bus.ram_wdata <= 32'h0;
            bus.ram_re    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.io_out    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant_dm;
                        last_grant <= grant_dm;
                        if (io_hit) begin
                            if (bus.dm_we) begin
                                if (bus.dm_addr == IO_OUT_ADDR) begin
                                    bus.io_out <= bus.dm_wdata;
                                end
                            end else if (bus.dm_addr == IO_IN0_ADDR) begin
                                bus.dm_rdata <= bus.io_in0;
                            end else begin
                                bus.dm_rdata <= bus.io_in1;
                            end
                            bus.dm_ack <= 1'b1;
                            state      <= DONE;
                        end else begin
                            bus.ram_addr  <= sel_addr;
                            bus.ram_wdata <= sel_wdata;
                            bus.ram_re    <= ~sel_we;
                            bus.ram_we    <= sel_we;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    bus.ram_addr  <= 32'h0;
                    bus.ram_wdata <= 32'h0;
                    bus.ram_re    <= 1'b0;
                    bus.ram_we    <= 1'b0;
                    if (bus.ram_we) begin
                        bus.if_ack <= (owner == OWN_IF);
                        bus.dm_ack <= (owner == OWN_DM);
                        state      <= DONE;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        if (owner == OWN_IF) begin
                            bus.if_rdata <= bus.ram_rdata;
                        end else begin
                            bus.dm_rdata <= bus.ram_rdata;
                        end
                        bus.if_ack <= (owner == OWN_IF);
                        bus.dm_ack <= (owner == OWN_DM);
                        state      <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                DONE: begin
                    bus.if_ack <= 1'b0;
                    bus.dm_ack <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives two arbiter instances (RD_LAT=1 and RD_LAT=4) through one set of
// requester tasks; 'sel' chooses which instance is live. A behavioural RAM
// returns read data exactly RD_LAT cycles after the ram_re cycle and garbage
// otherwise. Expected completions (owner, ack cycle, read data) are queued as
// requests are driven and popped by a monitor when an ack appears.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    bit          sel;

    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] io_in0;
    logic [31:0] io_in1;
    logic [31:0] ram_rdata;

    mem_port_arbiter_if bus_a ();
    mem_port_arbiter_if bus_b ();

    mem_port_arbiter #(.RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mem_port_arbiter #(.RD_LAT(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    assign bus_a.if_req    = if_req & ~sel;
    assign bus_a.if_addr   = if_addr;
    assign bus_a.dm_req    = dm_req & ~sel;
    assign bus_a.dm_we     = dm_we;
    assign bus_a.dm_addr   = dm_addr;
    assign bus_a.dm_wdata  = dm_wdata;
    assign bus_a.ram_rdata = ram_rdata;
    assign bus_a.io_in0    = io_in0;
    assign bus_a.io_in1    = io_in1;

    assign bus_b.if_req    = if_req & sel;
    assign bus_b.if_addr   = if_addr;
    assign bus_b.dm_req    = dm_req & sel;
    assign bus_b.dm_we     = dm_we;
    assign bus_b.dm_addr   = dm_addr;
    assign bus_b.dm_wdata  = dm_wdata;
    assign bus_b.ram_rdata = ram_rdata;
    assign bus_b.io_in0    = io_in0;
    assign bus_b.io_in1    = io_in1;

    wire logic [31:0] m_if_rdata  = sel ? bus_b.if_rdata  : bus_a.if_rdata;
    wire logic        m_if_ack    = sel ? bus_b.if_ack    : bus_a.if_ack;
    wire logic [31:0] m_dm_rdata  = sel ? bus_b.dm_rdata  : bus_a.dm_rdata;
    wire logic        m_dm_ack    = sel ? bus_b.dm_ack    : bus_a.dm_ack;
    wire logic [31:0] m_ram_addr  = sel ? bus_b.ram_addr  : bus_a.ram_addr;
    wire logic [31:0] m_ram_wdata = sel ? bus_b.ram_wdata : bus_a.ram_wdata;
    wire logic        m_ram_re    = sel ? bus_b.ram_re    : bus_a.ram_re;
    wire logic        m_ram_we    = sel ? bus_b.ram_we    : bus_a.ram_we;
    wire logic [31:0] m_io_out    = sel ? bus_b.io_out    : bus_a.io_out;

    typedef struct {
        bit          owner;
        bit          is_read;
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    int          cyc;
    int          re_count;
    int          we_count;
    logic [31:0] last_re_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: preloaded words until written, RD_LAT-deep read pipe
    function automatic logic [31:0] preload(input logic [31:0] a);
        case (a)
            32'h00000100: return 32'h8C010004;
            32'h00000200: return 32'h11112222;
            32'h00000040: return 32'h40404040;
            32'h0000FFF8: return 32'hCAFEF00D;
            default:      return a ^ 32'h5A5A0000;
        endcase
    endfunction

    logic [31:0] mem     [0:16383];
    bit          written [0:16383];
    logic [31:0] pipe    [0:7];

    always @(posedge clk) begin
        if (m_ram_we) begin
            mem[m_ram_addr[15:2]]     <= m_ram_wdata;
            written[m_ram_addr[15:2]] <= 1'b1;
        end
        if (m_ram_re) begin
            pipe[0] <= written[m_ram_addr[15:2]] ? mem[m_ram_addr[15:2]] : preload(m_ram_addr);
        end else begin
            pipe[0] <= 32'hBAD0BAD0;
        end
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    assign ram_rdata = sel ? pipe[3] : pipe[0];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // Monitor: strobe bookkeeping and scoreboard pops on every ack
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m_ram_re) begin
                re_count++;
                last_re_addr = m_ram_addr;
            end
            if (m_ram_we) we_count++;
            if (m_if_ack || m_dm_ack) begin
                checkOutput("ack_overlap", 32'(m_if_ack & m_dm_ack), 32'h0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ack_owner", 32'(m_dm_ack), 32'(e.owner));
                    checkOutput("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                    checkOutput("ram_addr_outside_issue", m_ram_addr, 32'h0);
                    if (e.is_read) begin
                        checkOutput(e.owner ? "dm_rdata" : "if_rdata",
                                    e.owner ? m_dm_rdata : m_if_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_io_out"},   m_io_out,   32'h0);
        checkOutput({tag, "_if_rdata"}, m_if_rdata, 32'h0);
        checkOutput({tag, "_dm_rdata"}, m_dm_rdata, 32'h0);
        checkOutput({tag, "_ram_addr"}, m_ram_addr, 32'h0);
        checkOutput({tag, "_strobes"},
                    {27'h0, m_ram_re, m_ram_we, m_if_ack, m_dm_ack, |m_ram_wdata}, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One request, held until its ack; called with the DUT idle at posedge+1
    task automatic applyStimulus(input bit owner, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input int lat);
        bit got;
        sb.push_back('{owner, !we, exp_data, cyc + lat});
        if (owner) begin
            dm_we    = we;
            dm_addr  = addr;
            dm_wdata = wdata;
            dm_req   = 1'b1;
        end else begin
            if_addr = addr;
            if_req  = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (owner ? m_dm_ack : m_if_ack) got = 1'b1;
        end
        if (!got) begin
            checkOutput("ack_timeout", 32'h0, 32'h1);
            sb.delete();
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r0;
        int w0;
        int n;
        rst      = 1'b1;
        sel      = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        io_in0   = 32'h00001234;
        io_in1   = 32'h00005678;

        // Reset state of the RD_LAT=1 instance
        repeat (2) @(posedge clk);
        #1;
        checkZeros("reset");
        rst = 1'b0;

        // IF read: one ram_re pulse at 0x100, ack 3 cycles after sampling
        r0 = re_count;
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 32'h8C010004, 3);
        checkOutput("if_ram_re_pulses", 32'(re_count - r0), 32'h1);
        checkOutput("if_ram_re_addr", last_re_addr, 32'h100);

        // Tie from reset: IF, DM, IF with both requests held throughout
        doReset();
        sb.push_back('{1'b0, 1'b1, 32'h8C010004, cyc + 3});
        sb.push_back('{1'b1, 1'b1, 32'h11112222, cyc + 7});
        sb.push_back('{1'b0, 1'b1, 32'h8C010004, cyc + 11});
        if_addr = 32'h100;
        dm_we   = 1'b0;
        dm_addr = 32'h200;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            @(negedge clk);
            if (m_if_ack || m_dm_ack) n++;
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        checkOutput("tie_ack_count", 32'(n), 32'h3);
        if (n < 3) sb.delete();

        // IO accesses never touch RAM
        r0 = re_count;
        w0 = we_count;
        applyStimulus(1'b1, 1'b1, 32'h0000FFFC, 32'hA5A5A5A5, 32'h0, 1);
        checkOutput("io_out_write", m_io_out, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 32'h0000FFF8, 32'h0, 32'h00001234, 1);
        applyStimulus(1'b1, 1'b0, 32'h0000FFFC, 32'h0, 32'h00005678, 1);
        applyStimulus(1'b1, 1'b1, 32'h0000FFF8, 32'h0BADF00D, 32'h0, 1);
        checkOutput("io_in0_write_ignored", m_io_out, 32'hA5A5A5A5);
        checkOutput("io_ram_we_pulses", 32'(we_count - w0), 32'h0);
        checkOutput("io_ram_re_pulses", 32'(re_count - r0), 32'h0);

        // IF at the IO address is an ordinary RAM read
        r0 = re_count;
        applyStimulus(1'b0, 1'b0, 32'h0000FFF8, 32'h0, 32'hCAFEF00D, 3);
        checkOutput("if_fff8_ram_re", 32'(re_count - r0), 32'h1);

        // Store then load back through RAM
        w0 = we_count;
        applyStimulus(1'b1, 1'b1, 32'h300, 32'hDEADBEEF, 32'h0, 2);
        checkOutput("store_ram_we_pulses", 32'(we_count - w0), 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 32'hDEADBEEF, 3);
        checkOutput("if_rdata_held", m_if_rdata, 32'hCAFEF00D);

        // RD_LAT=4 instance
        sel = 1'b1;
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 32'h40404040, 6);
        applyStimulus(1'b1, 1'b1, 32'h0000FFFC, 32'h5A5A5A5A, 32'h0, 1);
        checkOutput("lat4_io_out", m_io_out, 32'h5A5A5A5A);

        // Reset during WAIT of a DM load: no ack, everything back to zero
        dm_we   = 1'b0;
        dm_addr = 32'h40;
        dm_req  = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        dm_req = 1'b0;
        #1;
        checkZeros("midwait_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_if_ack || m_dm_ack) n++;
        end
        checkOutput("ack_after_reset", 32'(n), 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 32'h8C010004, 6);

        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
